scan_pq: RTL and testbench

//  Device-side (responder) priority queue on the pq_if handshake: accepts enq/deq/replace

---
 rtl/pq_pkg.sv | 17 +
 rtl/scan_pq.sv | 113 +++++++++++
 tb/tb_scan_pq.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pq_pkg.sv
// Shared priority-queue types: key/value entry layout and the ordering helper.
package pq_pkg;

  localparam int unsigned KEY_W = 8;
  localparam int unsigned VAL_W = 8;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] value;
  } kv_t;

  // Ordering looks at the key only; smaller key means higher priority.
  function automatic logic kv_lt(input kv_t a, input kv_t b);
    return a.key < b.key;
  endfunction

endpackage

// File: rtl/scan_pq.sv
// Register-array priority queue presenting the minimum-key entry on kvo.
// Removal and replace trigger a linear scan of the compact array, one slot per cycle.
module scan_pq
  import pq_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  kv_t  kvi,
  input  logic enq,
  input  logic deq,
  output kv_t  kvo,
  output logic full,
  output logic empty,
  output logic busy
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state;
  kv_t           slot [DEPTH];
  logic [CW-1:0] count;
  logic [IW-1:0] head_idx;
  logic [IW-1:0] scan_idx;
  logic [IW-1:0] last_idx;
  kv_t           min_kv;
  logic [IW-1:0] min_idx;

  logic          do_enq;
  logic          do_deq;
  logic          do_rep;
  kv_t           cand_kv;
  logic          take;
  kv_t           next_min;
  logic [IW-1:0] next_idx;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign last_idx = IW'(count - CW'(1));

  always_comb begin
    do_enq = 1'b0;
    do_deq = 1'b0;
    do_rep = 1'b0;
    if (state == IDLE) begin
      // enq&deq on an empty queue degrades to a plain enqueue
      if (enq && deq && !empty)
        do_rep = 1'b1;
      else if (enq && !full)
        do_enq = 1'b1;
      else if (deq && !enq && !empty)
        do_deq = 1'b1;
    end
  end

  always_comb begin
    cand_kv  = slot[scan_idx];
    take     = (scan_idx == '0) || kv_lt(cand_kv, min_kv);
    next_min = take ? cand_kv  : min_kv;
    next_idx = take ? scan_idx : min_idx;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      count    <= '0;
      kvo      <= '0;
      busy     <= 1'b0;
      head_idx <= '0;
      scan_idx <= '0;
      min_kv   <= '0;
      min_idx  <= '0;
    end else if (state == IDLE) begin
      if (do_enq) begin
        slot[IW'(count)] <= kvi;
        count            <= count + CW'(1);
        if (empty || kv_lt(kvi, kvo)) begin
          kvo      <= kvi;
          head_idx <= IW'(count);
        end
      end else if (do_rep) begin
        slot[head_idx] <= kvi;
        scan_idx       <= '0;
        busy           <= 1'b1;
        state          <= SCAN;
      end else if (do_deq) begin
        // Backfill the hole with the last entry to keep slots [0..count-1] compact
        slot[head_idx] <= slot[last_idx];
        count          <= count - CW'(1);
        if (count != CW'(1)) begin
          scan_idx <= '0;
          busy     <= 1'b1;
          state    <= SCAN;
        end
      end
    end else begin
      min_kv   <= next_min;
      min_idx  <= next_idx;
      scan_idx <= scan_idx + IW'(1);
      if (scan_idx == last_idx) begin
        kvo      <= next_min;
        head_idx <= next_idx;
        busy     <= 1'b0;
        state    <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_scan_pq.sv
// Randomized and directed bench for scan_pq against a slot-array behavioural model.
module tb_scan_pq;
  import pq_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst;
  kv_t  kvi;
  logic enq;
  logic deq;
  kv_t  kvo;
  logic full;
  logic empty;
  logic busy;

  int unsigned n_vec;
  int unsigned n_err;

  kv_t m_arr [DEPTH];
  int  m_cnt;
  int  m_busy;
  kv_t m_kvo;

  scan_pq #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .kvi   (kvi),
    .enq   (enq),
    .deq   (deq),
    .kvo   (kvo),
    .full  (full),
    .empty (empty),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // First slot holding the smallest key: the queue head under lower-index tie-break
  function automatic int head_of();
    int h;
    h = 0;
    for (int i = 1; i < m_cnt; i++)
      if (m_arr[i].key < m_arr[h].key) h = i;
    return h;
  endfunction

  task automatic model(input logic r, input logic e, input logic d, input kv_t k);
    int h;
    if (!r) begin
      m_cnt  = 0;
      m_busy = 0;
      m_kvo  = '0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) m_kvo = m_arr[head_of()];
    end else if (e && d && m_cnt > 0) begin
      m_arr[head_of()] = k;
      m_busy = m_cnt;
    end else if (e) begin
      if (m_cnt < DEPTH) begin
        m_arr[m_cnt] = k;
        m_cnt++;
        m_kvo = m_arr[head_of()];
      end
    end else if (d && m_cnt > 0) begin
      h = head_of();
      m_arr[h] = m_arr[m_cnt-1];
      m_cnt--;
      if (m_cnt > 0) m_busy = m_cnt;
    end
  endtask

  task automatic step(input logic r, input logic e, input logic d, input logic [15:0] k);
    rst = r;
    enq = e;
    deq = d;
    kvi = k;
    @(posedge clk);
    model(r, e, d, k);
    #1;
    check("kvo",   kvo,   m_kvo);
    check("busy",  {15'd0, busy},  {15'd0, m_busy > 0});
    check("empty", {15'd0, empty}, {15'd0, m_cnt == 0});
    check("full",  {15'd0, full},  {15'd0, m_cnt == DEPTH});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 16'h0000);
  endtask

  initial begin
    int r;
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    enq = 1'b0;
    deq = 1'b0;
    kvi = '0;

    // Reset with an enqueue attempt held during it
    step(1'b0, 1'b1, 1'b0, 16'h5566);
    step(1'b0, 1'b1, 1'b0, 16'h5566);
    check("rst_kvo_const", kvo, 16'h0000);
    check("rst_empty_const", {15'd0, empty}, 16'd1);

    // Basic enqueue ordering and dequeue scans
    step(1'b1, 1'b1, 1'b0, 16'h3011);
    step(1'b1, 1'b1, 1'b0, 16'h1022);
    step(1'b1, 1'b1, 1'b0, 16'h2033);
    check("enq_head_const", kvo, 16'h1022);
    step(1'b1, 1'b0, 1'b1, 16'h0000);
    idle(2);
    check("deq1_const", kvo, 16'h2033);
    step(1'b1, 1'b0, 1'b1, 16'h0000);
    idle(1);
    check("deq2_const", kvo, 16'h3011);
    step(1'b1, 1'b0, 1'b1, 16'h0000);
    idle(1);

    // Fill, overflow attempt, replace on full with requests pulsed mid-scan
    step(1'b1, 1'b1, 1'b0, 16'h4011);
    step(1'b1, 1'b1, 1'b0, 16'h1022);
    step(1'b1, 1'b1, 1'b0, 16'h3033);
    step(1'b1, 1'b1, 1'b0, 16'h2044);
    step(1'b1, 1'b1, 1'b0, 16'h0000);
    check("ovf_head_const", kvo, 16'h1022);
    step(1'b1, 1'b1, 1'b1, 16'h0555);
    step(1'b1, 1'b0, 1'b1, 16'h0000);
    step(1'b1, 1'b1, 1'b0, 16'h0101);
    idle(2);
    check("rep_head_const", kvo, 16'h0555);
    check("rep_full_const", {15'd0, full}, 16'd1);

    // Equal keys, then reset in the middle of a scan
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 1'b0, 16'h2011);
    step(1'b1, 1'b1, 1'b0, 16'h2022);
    check("tie_head_const", kvo, 16'h2011);
    step(1'b1, 1'b0, 1'b1, 16'h0000);
    idle(1);
    check("tie_deq_const", kvo, 16'h2022);
    step(1'b1, 1'b1, 1'b0, 16'h1033);
    step(1'b1, 1'b1, 1'b1, 16'h4044);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    idle(2);

    // Random traffic with a narrow key range to exercise ties
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 99);
      step(r >= 2, r >= 2 && r < 60, r >= 40, {4'h0, 4'($urandom_range(0, 7)), 8'($urandom)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
